frame_queue_ctrl: RTL and testbench

//  Accepts bytes from the framer and writes the payload of each valid frame into an
//  on-chip circular byte queue. Frame boundaries come from the framer's sync byte and
//  a length byte. The consumer sees only complete frames; partial or oversize frames
//  are rolled back and counted. The block sits between the framer outputs and the

---
 rtl/frame_queue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_frame_queue_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_queue_ctrl.sv
// Frame-aware circular byte queue.
// Payload bytes are written speculatively; they become visible to the reader
// only when the last byte of the frame lands, which moves commit_ptr.
// Bad or aborted frames roll wr_ptr back to commit_ptr and bump drop_cnt.
module frame_queue_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic          ser_clk,
  input  logic          reset,
  input  logic [7:0]    byte_in,
  input  logic          byte_stb,
  input  logic          sync_det,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          frame_done,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {StHunt, StLen, StPayload, StDrop} state_e;

  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  mem [DEPTH];

  logic [AW:0] level_w;
  logic [7:0]  free_w;
  logic        empty_w;
  logic        rd_en;
  logic        wr_en;
  logic        drop_inc;

  // Committed occupancy and status; uncommitted bytes never count.
  always_comb begin
    level_w = commit_ptr_q - rd_ptr_q;
    free_w  = 8'(DEPTH) - 8'(level_w);
    empty_w = (commit_ptr_q == rd_ptr_q);
    rd_en   = rd_req && !empty_w;
  end

  assign level      = level_w;
  assign empty      = empty_w;
  assign full       = (commit_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (commit_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign busy       = (state_q != StHunt);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;

  // Frame parser: next state, write pointer, commit and drop accounting.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    drop_inc     = 1'b0;
    wr_en        = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StHunt: begin
        if (byte_stb && sync_det) state_d = StLen;
      end
      StLen: begin
        // A repeated sync simply re-arms the length capture.
        if (byte_stb && !sync_det) begin
          if (byte_in == 8'd0 || byte_in > 8'(MAX_LEN)) begin
            drop_inc = 1'b1;
            state_d  = StHunt;
          end else if (byte_in > free_w) begin
            drop_inc = 1'b1;
            cnt_d    = byte_in;
            state_d  = StDrop;
          end else begin
            cnt_d    = byte_in;
            state_d  = StPayload;
          end
        end
      end
      StPayload: begin
        if (byte_stb) begin
          if (sync_det) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = StLen;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            cnt_d    = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              commit_ptr_d = wr_ptr_q + PtrOne;
              frame_done_d = 1'b1;
              state_d      = StHunt;
            end
          end
        end
      end
      StDrop: begin
        if (byte_stb) begin
          if (sync_det) begin
            state_d = StLen;
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // Read pointer advance and saturating drop counter.
  always_comb begin
    rd_ptr_d   = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;
    drop_cnt_d = (drop_inc && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // State and pointer registers.
  always_ff @(posedge ser_clk) begin
    if (reset) begin
      state_q      <= StHunt;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      drop_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_en;
      if (rd_en) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Queue storage; contents are invalidated by pointer reset, not cleared.
  always_ff @(posedge ser_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= byte_in;
  end

endmodule

// File: tb/tb_frame_queue_ctrl.sv
// Directed bench for frame_queue_ctrl.
module tb_frame_queue_ctrl;

  logic       ser_clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_stb;
  logic       sync_det;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       frame_done;
  logic [7:0] drop_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  frame_queue_ctrl #(
    .DEPTH  (16),
    .AW     (4),
    .MAX_LEN(15)
  ) dut (
    .ser_clk   (ser_clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .byte_stb  (byte_stb),
    .sync_det  (sync_det),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 ser_clk = ~ser_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ser_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    byte_in  = b;
    byte_stb = 1'b1;
    sync_det = s;
    tick();
    byte_stb = 1'b0;
    sync_det = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [7:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_eq({tag, "_valid"}, rd_valid, 1);
    check_eq({tag, "_data"}, rd_data, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_empty"}, empty, 1);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_level"}, level, 0);
    check_eq({tag, "_drop"}, drop_cnt, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_rdv"}, rd_valid, 0);
    check_eq({tag, "_rdd"}, rd_data, 0);
    check_eq({tag, "_done"}, frame_done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Streaming read checker: every rd_valid must match the next expected byte.
  always @(negedge ser_clk) begin
    if (mon_en) begin
      check_eq("t5_level_le_depth", 32'(level <= 5'd16), 1);
      if (rd_valid) begin
        if (exp_q.size() == 0) check_eq("t5_spurious_valid", rd_valid, 0);
        else check_eq("t5_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset    = 1'b1;
    byte_in  = '0;
    byte_stb = 1'b0;
    sync_det = 1'b0;
    rd_req   = 1'b0;
    do_reset();
    check_reset_state("rst");

    // T1: basic frame and readback
    send_byte(8'hB8, 1'b1);
    check_eq("t1_busy", busy, 1);
    send_byte(8'd3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check_eq("t1_level_uncommitted", level, 0);
    send_byte(8'h33, 1'b0);
    check_eq("t1_done", frame_done, 1);
    check_eq("t1_level", level, 3);
    check_eq("t1_busy_end", busy, 0);
    tick();
    check_eq("t1_done_pulse", frame_done, 0);
    read_one("t1_r0", 8'h11);
    read_one("t1_r1", 8'h22);
    read_one("t1_r2", 8'h33);
    check_eq("t1_empty", empty, 1);
    tick();
    check_eq("t1_rdv_low", rd_valid, 0);

    // T2: sync aborts a partial frame, then a 1-byte frame from LEN
    send_byte(8'hB8, 1'b1);
    send_byte(8'd4, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hB8, 1'b1);
    check_eq("t2_drop", drop_cnt, 1);
    check_eq("t2_level", level, 0);
    check_eq("t2_busy_len", busy, 1);
    send_byte(8'd1, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_eq("t2_level1", level, 1);
    read_one("t2_r", 8'h5A);

    // T3: oversize-for-free frame is consumed and dropped; exact fit commits
    send_byte(8'hB8, 1'b1);
    send_byte(8'd14, 1'b0);
    for (int i = 0; i < 14; i++) send_byte(8'(8'h30 + i), 1'b0);
    check_eq("t3_level14", level, 14);
    send_byte(8'hB8, 1'b1);
    send_byte(8'd3, 1'b0);
    check_eq("t3_drop", drop_cnt, 2);
    check_eq("t3_busy_drop", busy, 1);
    send_byte(8'hF1, 1'b0);
    send_byte(8'hF2, 1'b0);
    send_byte(8'hF3, 1'b0);
    check_eq("t3_busy_after", busy, 0);
    check_eq("t3_level_kept", level, 14);
    send_byte(8'hB8, 1'b1);
    send_byte(8'd2, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hE1, 1'b0);
    check_eq("t3_full", full, 1);
    check_eq("t3_level16", level, 16);
    for (int i = 0; i < 14; i++) read_one("t3_r", 8'(8'h30 + i));
    read_one("t3_re0", 8'hE0);
    read_one("t3_re1", 8'hE1);
    check_eq("t3_empty", empty, 1);

    // T4: illegal lengths and ignored HUNT bytes
    send_byte(8'hB8, 1'b1);
    send_byte(8'd0, 1'b0);
    check_eq("t4_drop_l0", drop_cnt, 3);
    check_eq("t4_hunt_l0", busy, 0);
    send_byte(8'hB8, 1'b1);
    send_byte(8'd16, 1'b0);
    check_eq("t4_drop_l16", drop_cnt, 4);
    check_eq("t4_hunt_l16", busy, 0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h77, 1'b0);
    check_eq("t4_hunt_ignored", busy, 0);
    check_eq("t4_level", level, 0);

    // T5: 40 frames with continuous reads, wrapping many times
    mon_en = 1'b1;
    rd_req = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_byte(8'hB8, 1'b1);
      send_byte(8'd5, 1'b0);
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back(8'(f * 5 + i));
        send_byte(8'(f * 5 + i), 1'b0);
      end
    end
    repeat (20) tick();
    mon_en = 1'b0;
    check_eq("t5_all_read", exp_q.size(), 0);
    check_eq("t5_empty", empty, 1);
    check_eq("t5_rdv_empty", rd_valid, 0);
    check_eq("t5_rdd_hold", rd_data, 8'hC7);
    check_eq("t5_drop_same", drop_cnt, 4);
    rd_req = 1'b0;

    // T6: reset mid-frame, then a fresh frame
    send_byte(8'hB8, 1'b1);
    send_byte(8'd6, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h90 + i), 1'b0);
    check_eq("t6_level6", level, 6);
    send_byte(8'hB8, 1'b1);
    send_byte(8'd4, 1'b0);
    send_byte(8'hAA, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6_rst");
    send_byte(8'hB8, 1'b1);
    send_byte(8'd2, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    check_eq("t6_done", frame_done, 1);
    check_eq("t6_level", level, 2);
    read_one("t6_r0", 8'hC1);
    read_one("t6_r1", 8'hC2);
    check_eq("t6_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
